// File: rtl/lockpick_key_feeder.sv
// lockpick_key_feeder: host byte FIFO plus attempt sequencer for the lockpick
// game core. It sends start once, streams 64 key bytes per attempt (key A then
// key B), retries on an error status, and stops on a win, a lockout or a lost game.
// Optional: define LOCKPICK_FEEDER_CKSUM_EN to build the per-attempt XOR checksum;
// without it cksum reads 0x00.
module lockpick_key_feeder #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       start,
  output logic       input_enable,
  output logic [7:0] input_data,
  input  logic       game_output_valid,
  input  logic [1:0] game_status,
  output logic       done,
  output logic [1:0] result,
  output logic [1:0] attempt,
  output logic [7:0] cksum
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [6:0]  KEY_BYTES = 7'd64;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_FEED    = 3'd2;
  localparam logic [2:0] S_WAIT_HI = 3'd3;
  localparam logic [2:0] S_WAIT_LO = 3'd4;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [2:0]    state;
  logic [6:0]    sent;
  logic          push, pop;
  logic [7:0]    pop_byte;

  // flush wins over a same-cycle push; pops only happen while streaming
  assign in_ready = (count != FULL);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (state == S_FEED) && (count != '0) && (sent < KEY_BYTES) && !flush;
  assign pop_byte = mem[rd_ptr];

  // FIFO storage: data only, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == AW'(DEPTH-1)) ? '0 : wr_ptr + AW'(1);
      if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH-1)) ? '0 : rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // attempt sequencer: start pulse, byte stream, result-burst handling
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      sent         <= '0;
      attempt      <= '0;
      result       <= '0;
      start        <= 1'b0;
      input_enable <= 1'b0;
      input_data   <= '0;
      done         <= 1'b0;
    end else begin
      start        <= 1'b0;
      input_enable <= 1'b0;
      done         <= 1'b0;
      if (flush) begin
        state   <= S_IDLE;
        sent    <= '0;
        attempt <= '0;
      end else begin
        case (state)
          S_IDLE: if (go) begin
            attempt <= '0;
            result  <= '0;
            sent    <= '0;
            start   <= 1'b1;
            state   <= S_START;
          end
          S_START: state <= S_FEED;
          S_FEED: if (pop) begin
            input_enable <= 1'b1;
            input_data   <= pop_byte;
            sent         <= sent + 7'd1;
            if (sent == KEY_BYTES - 7'd1) state <= S_WAIT_HI;
          end
          S_WAIT_HI: if (game_output_valid) state <= S_WAIT_LO;
          S_WAIT_LO: if (!game_output_valid) begin
            if (game_status == 2'b01) begin
              // game re-enters key-A entry on its own, so no start here
              if (attempt != 2'd3) attempt <= attempt + 2'd1;
              sent  <= '0;
              state <= S_FEED;
            end else begin
              // 10 win, 11 lockout, 00 lost: status maps straight onto result
              result <= game_status;
              done   <= 1'b1;
              state  <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef LOCKPICK_FEEDER_CKSUM_EN
  logic ck_clr;
  assign ck_clr = ((state == S_IDLE) && go) ||
                  ((state == S_WAIT_LO) && !game_output_valid && (game_status == 2'b01));

  // running XOR of the bytes sent in the current attempt
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                cksum <= '0;
    else if (flush || ck_clr) cksum <= '0;
    else if (pop)            cksum <= cksum ^ pop_byte;
  end
`else
  assign cksum = 8'h00;
`endif

endmodule
